smallseg_g0_update_ctrl: RTL and testbench
==========================================

Name: smallseg_g0_update_ctrl

Overview:
- Update-side initiator for one small-segment/G0 rule table (1739 x 171-bit block RAM, 1-cycle registered read).
- Accepts insert/delete commands from the update engine over a valid/ready channel and allocates or frees table indices.
- Drives the table's addr/we/din port, runs read-modify-write checks through its dout, and returns a status response.
- One instance per table; one instance per (subset, table) pair in the classifier.

Parameters:
TABLE_ENTRY_SIZE, 1738, highest valid table index; the table holds TABLE_ENTRY_SIZE+1 entries.
INIT_FILL, 0, number of entries preloaded from the table init file; first never-used index after reset.
FREE_DEPTH, 16, depth of the LIFO holding freed indices (power of 2).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts command (high only in IDLE)
cmd_op  in  1  0=insert, 1=delete
cmd_rule  in  149  srcIP32|srcLen6|dstIP32|dstLen6|sp_hi16|sp_lo16|dp_hi16|dp_lo16|proto8|wildcard1
cmd_rule_id  in  11  rule ID
cmd_index  in  11  target index (delete only)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_status  out  2  00 OK, 01 TABLE_FULL, 10 ID_MISMATCH, 11 BAD_INDEX
rsp_index  out  11  allocated (insert) or freed (delete) index
tbl_addr  out  11  table address
tbl_we  out  1  table write enable
tbl_din  out  171  table write data
tbl_dout  in  171  table read data
free_cnt  out  5  entries in free LIFO (log2(FREE_DEPTH)+1)
leak_cnt  out  8  saturating count of freed indices dropped on LIFO overflow

Behaviour:
- Reset values:
  - outputs: cmd_ready=0, rsp_valid=0, rsp_status=0, rsp_index=0, tbl_addr=0, tbl_we=0, tbl_din=0, free_cnt=0, leak_cnt=0.
  - internal: hwm=INIT_FILL, LIFO empty, FSM=IDLE.
- Reset mid-operation aborts immediately; a partially issued write is not completed (tbl_we drops asynchronously).
- All outputs are registered. Entry word = {cmd_rule[148:0], rule_id[10:0], index[10:0]}, so bits [170:22], [21:11], [10:0].
- FSM states: IDLE, ALLOC, WRITE, RD_ISSUE, RD_WAIT, CHECK, RESP.
- IDLE: cmd_ready=1; command captured on cmd_valid&cmd_ready. Insert -> ALLOC; delete -> RD_ISSUE, or RESP/BAD_INDEX if cmd_index>TABLE_ENTRY_SIZE.
- ALLOC:
  - if LIFO not empty: pop, index=popped value;
  - else if hwm<=TABLE_ENTRY_SIZE: index=hwm, hwm++;
  - else RESP/TABLE_FULL with rsp_index=0.
  - Otherwise -> WRITE.
- WRITE: tbl_we=1 for exactly one cycle, tbl_addr=index, tbl_din=entry word -> RESP/OK.
- RD_ISSUE: tbl_we=0, tbl_addr=cmd_index -> RD_WAIT.
- RD_WAIT: one idle cycle for the table's registered read -> CHECK.
- CHECK: samples tbl_dout, which is valid 2 cycles after RD_ISSUE.
  - If tbl_dout[21:11]!=cmd_rule_id: RESP/ID_MISMATCH, no write.
  - Else one-cycle write of all-zero to cmd_index, then push cmd_index onto the LIFO; if the LIFO is full the index is dropped and leak_cnt increments (saturating at 255). -> RESP/OK.
- Latency from accept to rsp_valid: insert 3 cycles; delete 4 cycles OK/mismatch; BAD_INDEX 1 cycle.
- RESP: rsp_valid held with stable status/index until rsp_ready; -> IDLE on handshake. Back-to-back throughput is at most one command per response.
- tbl_we is 0 in every state except the write cycle; tbl_addr holds its last value when idle.
- Insert never checks for duplicate rule IDs (update engine responsibility).
- free_cnt updates the cycle after push/pop.

Decomposition:
- Shared package smallseg_pkg:
  - entry field widths/offsets (IP 32, LEN 6, PORT 16, PROTO 8, ID 11, IDX 11, ENTRY 171);
  - opcode constants OP_INSERT/OP_DELETE;
  - status codes ST_OK/ST_FULL/ST_MISMATCH/ST_BADIDX;
  - FSM state encoding.
- One sub-module: smallseg_free_lifo (parameterised depth/width; push, pop, empty, full, count), instantiated once.
- FSM and entry packing stay in the top module.

Test Plan:
- INIT_FILL=5, insert rule_id=0x123 -> tbl_we pulse at addr 5, tbl_din[21:11]=0x123, [10:0]=5; rsp OK, rsp_index=5, 3 cycles after accept.
- Delete index 5 id 0x123 against a table model holding that entry -> write of 0 at addr 5; rsp OK index 5; free_cnt=1. Next insert -> rsp_index=5, free_cnt=0, hwm unchanged (next fresh insert gets 6).
- Delete index 5 id 0x124 with entry id 0x123 -> no tbl_we; rsp ID_MISMATCH. Delete index 1739 -> BAD_INDEX after 1 cycle, no table access.
- INIT_FILL=1738: two inserts -> first rsp index 1738 OK, second TABLE_FULL index 0.
- FREE_DEPTH=16: 17 valid deletes -> free_cnt=16, leak_cnt=1, all rsp OK. Hold rsp_ready=0 for 10 cycles -> rsp fields stable, cmd_ready=0.
- Assert rst during WRITE -> tbl_we=0 immediately, rsp_valid=0, hwm=INIT_FILL after release.

Source files
------------

// File: rtl/smallseg_pkg.sv
// Shared definitions for the small-segment/G0 table update path:
// entry layout, opcodes, response codes and the update FSM encoding.
package smallseg_pkg;

   localparam int IP_W    = 32;
   localparam int LEN_W   = 6;
   localparam int PORT_W  = 16;
   localparam int PROTO_W = 8;
   localparam int ID_W    = 11;
   localparam int IDX_W   = 11;

   // srcIP|srcLen|dstIP|dstLen|4 port bounds|proto|wildcard
   localparam int RULE_W  = 2*IP_W + 2*LEN_W + 4*PORT_W + PROTO_W + 1;
   localparam int ENTRY_W = RULE_W + ID_W + IDX_W;

   localparam int IDX_OFF  = 0;
   localparam int ID_OFF   = IDX_OFF + IDX_W;
   localparam int RULE_OFF = ID_OFF + ID_W;

   localparam logic OP_INSERT = 1'b0;
   localparam logic OP_DELETE = 1'b1;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_FULL     = 2'b01;
   localparam logic [1:0] ST_MISMATCH = 2'b10;
   localparam logic [1:0] ST_BADIDX   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALLOC,
      S_WRITE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_CHECK,
      S_RESP
   } state_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [RULE_W-1:0] rule,
      input logic [ID_W-1:0]   id,
      input logic [IDX_W-1:0]  idx
   );
      return {rule, id, idx};
   endfunction

endpackage

// File: rtl/smallseg_free_lifo.sv
// LIFO of freed table indices; top of stack is readable combinationally,
// count updates the cycle after push/pop, pushes while full are ignored.
module smallseg_free_lifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_cnt;
   logic [AW-1:0]    w_top;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == (AW+1)'(DEPTH));
   // At full the low bits wrap to zero, so top still lands on DEPTH-1.
   assign w_top     = r_cnt[AW-1:0] - AW'(1);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_dout    = r_mem[w_top];
   assign o_count   = r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         if (w_do_pop) begin
            r_mem[w_top] <= i_din;
         end else begin
            r_mem[r_cnt[AW-1:0]] <= i_din;
         end
      end
   end

endmodule

// File: rtl/smallseg_g0_update_ctrl.sv
// Insert/delete initiator for one rule table: allocates/frees indices, drives the RAM port.
// Accept->rsp_valid: insert 3, delete 4, bad index 1; one command in flight, rsp held until rsp_ready.
module smallseg_g0_update_ctrl
   import smallseg_pkg::*;
#(
   parameter int TABLE_ENTRY_SIZE = 1738,
   parameter int INIT_FILL        = 0,
   parameter int FREE_DEPTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_op,
   input  logic [RULE_W-1:0]             cmd_rule,
   input  logic [ID_W-1:0]               cmd_rule_id,
   input  logic [IDX_W-1:0]              cmd_index,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [1:0]                    rsp_status,
   output logic [IDX_W-1:0]              rsp_index,
   output logic [IDX_W-1:0]              tbl_addr,
   output logic                          tbl_we,
   output logic [ENTRY_W-1:0]            tbl_din,
   input  logic [ENTRY_W-1:0]            tbl_dout,
   output logic [$clog2(FREE_DEPTH):0]   free_cnt,
   output logic [7:0]                    leak_cnt
);

   localparam int HWM_W = IDX_W + 1;

   state_t               r_state;
   state_t               w_next;

   logic                 r_op;
   logic [RULE_W-1:0]    r_rule;
   logic [ID_W-1:0]      r_id;
   logic [IDX_W-1:0]     r_idx;
   logic [HWM_W-1:0]     r_hwm;

   logic                 r_cmd_ready;
   logic                 r_rsp_valid;
   logic [1:0]           r_rsp_status;
   logic [IDX_W-1:0]     r_rsp_index;
   logic [IDX_W-1:0]     r_tbl_addr;
   logic                 r_tbl_we;
   logic [ENTRY_W-1:0]   r_tbl_din;
   logic [7:0]           r_leak;

   logic                 w_accept;
   logic                 w_bad_idx;
   logic                 w_id_ok;
   logic                 w_have_fresh;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_hwm_inc;
   logic [IDX_W-1:0]     w_alloc_idx;
   logic [IDX_W-1:0]     w_lifo_dout;
   logic                 w_lifo_empty;
   logic                 w_lifo_full;
   logic                 w_unused_dout;

   assign w_accept      = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
   assign w_bad_idx     = (cmd_index > IDX_W'(TABLE_ENTRY_SIZE));
   assign w_id_ok       = (tbl_dout[ID_OFF +: ID_W] == r_id);
   assign w_have_fresh  = (r_hwm <= HWM_W'(TABLE_ENTRY_SIZE));
   assign w_alloc_idx   = w_lifo_empty ? r_hwm[IDX_W-1:0] : w_lifo_dout;
   assign w_unused_dout = ^{tbl_dout[ENTRY_W-1:RULE_OFF], tbl_dout[IDX_W-1:0], r_op};

   smallseg_free_lifo #(
      .DEPTH (FREE_DEPTH),
      .WIDTH (IDX_W)
   ) u_free_lifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (r_idx),
      .i_pop   (w_pop),
      .o_dout  (w_lifo_dout),
      .o_empty (w_lifo_empty),
      .o_full  (w_lifo_full),
      .o_count (free_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_hwm_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (cmd_op == OP_INSERT) begin
                  w_next = S_ALLOC;
               end else if (w_bad_idx) begin
                  w_next = S_RESP;
               end else begin
                  w_next = S_RD_ISSUE;
               end
            end
         end
         S_ALLOC: begin
            // Recycled indices are preferred so the fresh region grows only when needed.
            if (!w_lifo_empty) begin
               w_pop  = 1'b1;
               w_next = S_WRITE;
            end else if (w_have_fresh) begin
               w_hwm_inc = 1'b1;
               w_next    = S_WRITE;
            end else begin
               w_next = S_RESP;
            end
         end
         S_WRITE:    w_next = S_RESP;
         S_RD_ISSUE: w_next = S_RD_WAIT;
         S_RD_WAIT:  w_next = S_CHECK;
         S_CHECK: begin
            w_push = w_id_ok;
            w_next = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= OP_INSERT;
         r_rule       <= '0;
         r_id         <= '0;
         r_idx        <= '0;
         r_hwm        <= HWM_W'(INIT_FILL);
         r_cmd_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_status <= ST_OK;
         r_rsp_index  <= '0;
         r_tbl_addr   <= '0;
         r_tbl_we     <= 1'b0;
         r_tbl_din    <= '0;
      end else begin
         r_tbl_we    <= 1'b0;
         r_cmd_ready <= (w_next == S_IDLE);
         if (w_hwm_inc) begin
            r_hwm <= r_hwm + HWM_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op   <= cmd_op;
                  r_rule <= cmd_rule;
                  r_id   <= cmd_rule_id;
                  r_idx  <= cmd_index;
                  if (cmd_op == OP_DELETE && w_bad_idx) begin
                     r_rsp_valid  <= 1'b1;
                     r_rsp_status <= ST_BADIDX;
                     r_rsp_index  <= cmd_index;
                  end
               end
            end
            S_ALLOC: begin
               if (!w_lifo_empty || w_have_fresh) begin
                  r_tbl_we    <= 1'b1;
                  r_tbl_addr  <= w_alloc_idx;
                  r_tbl_din   <= pack_entry(r_rule, r_id, w_alloc_idx);
                  r_rsp_index <= w_alloc_idx;
               end else begin
                  r_rsp_valid  <= 1'b1;
                  r_rsp_status <= ST_FULL;
                  r_rsp_index  <= '0;
               end
            end
            S_WRITE: begin
               r_rsp_valid  <= 1'b1;
               r_rsp_status <= ST_OK;
            end
            S_RD_ISSUE: begin
               r_tbl_addr <= r_idx;
            end
            S_CHECK: begin
               r_rsp_valid <= 1'b1;
               r_rsp_index <= r_idx;
               if (w_id_ok) begin
                  r_tbl_we     <= 1'b1;
                  r_tbl_addr   <= r_idx;
                  r_tbl_din    <= '0;
                  r_rsp_status <= ST_OK;
               end else begin
                  r_rsp_status <= ST_MISMATCH;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_leak <= '0;
      end else if (w_push && w_lifo_full && r_leak != 8'hFF) begin
         r_leak <= r_leak + 8'd1;
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_status = r_rsp_status;
   assign rsp_index  = r_rsp_index;
   assign tbl_addr   = r_tbl_addr;
   assign tbl_we     = r_tbl_we;
   assign tbl_din    = r_tbl_din;
   assign leak_cnt   = r_leak;

endmodule

// File: tb/tb_smallseg_g0_update_ctrl.sv
// Directed bench: two controller instances (INIT_FILL=5 with a RAM model, INIT_FILL=1738 for full).
module tb_smallseg_g0_update_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_cmd_valid, b_cmd_valid;
   logic          cmd_op;
   logic [148:0]  cmd_rule;
   logic [10:0]   cmd_rule_id;
   logic [10:0]   cmd_index;
   logic          rsp_ready;
   logic          preload;

   logic          a_cmd_ready, a_rsp_valid, a_tbl_we;
   logic [1:0]    a_rsp_status;
   logic [10:0]   a_rsp_index, a_tbl_addr;
   logic [170:0]  a_tbl_din, a_tbl_dout;
   logic [4:0]    a_free_cnt;
   logic [7:0]    a_leak_cnt;

   logic          b_cmd_ready, b_rsp_valid, b_tbl_we;
   logic [1:0]    b_rsp_status;
   logic [10:0]   b_rsp_index, b_tbl_addr;
   logic [170:0]  b_tbl_din;
   logic [170:0]  b_tbl_dout;
   logic [4:0]    b_free_cnt;
   logic [7:0]    b_leak_cnt;

   assign b_tbl_dout = '0;

   smallseg_g0_update_ctrl #(.TABLE_ENTRY_SIZE(1738), .INIT_FILL(5), .FREE_DEPTH(16)) u_dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(cmd_op),
      .cmd_rule(cmd_rule), .cmd_rule_id(cmd_rule_id), .cmd_index(cmd_index),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_status(a_rsp_status), .rsp_index(a_rsp_index),
      .tbl_addr(a_tbl_addr), .tbl_we(a_tbl_we), .tbl_din(a_tbl_din), .tbl_dout(a_tbl_dout),
      .free_cnt(a_free_cnt), .leak_cnt(a_leak_cnt));

   smallseg_g0_update_ctrl #(.TABLE_ENTRY_SIZE(1738), .INIT_FILL(1738), .FREE_DEPTH(16)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(cmd_op),
      .cmd_rule(cmd_rule), .cmd_rule_id(cmd_rule_id), .cmd_index(cmd_index),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_status(b_rsp_status), .rsp_index(b_rsp_index),
      .tbl_addr(b_tbl_addr), .tbl_we(b_tbl_we), .tbl_din(b_tbl_din), .tbl_dout(b_tbl_dout),
      .free_cnt(b_free_cnt), .leak_cnt(b_leak_cnt));

   // Table model: 1739 entries, registered read; entry i preloaded with rule_id=i, index=i.
   logic [170:0] tbl_mem [0:1738];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1739; i++) tbl_mem[i] <= {149'b0, 11'(i), 11'(i)};
      end else begin
         if (a_tbl_we) tbl_mem[a_tbl_addr] <= a_tbl_din;
         a_tbl_dout <= tbl_mem[a_tbl_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [170:0] got, input logic [170:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [1:0]   res_st;
   logic [10:0]  res_ix;
   int           res_lat;
   int           res_we_cnt;
   logic [10:0]  res_we_addr;
   logic [170:0] res_we_din;

   task automatic run_cmd(input bit sel, input logic op, input logic [10:0] id,
                          input logic [10:0] idx, input logic [148:0] rule, input bit ack);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!(sel ? b_cmd_ready : a_cmd_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_wait", 171'(guard < 50), 171'(1));
      cmd_op = op; cmd_rule_id = id; cmd_index = idx; cmd_rule = rule;
      if (sel) b_cmd_valid = 1'b1; else a_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      a_cmd_valid = 1'b0;
      b_cmd_valid = 1'b0;
      res_lat = 0;
      res_we_cnt = 0;
      res_we_addr = '0;
      res_we_din = '0;
      do begin
         @(negedge clk);
         res_lat++;
         if (sel ? b_tbl_we : a_tbl_we) begin
            res_we_cnt++;
            res_we_addr = sel ? b_tbl_addr : a_tbl_addr;
            res_we_din  = sel ? b_tbl_din : a_tbl_din;
         end
      end while (!(sel ? b_rsp_valid : a_rsp_valid) && res_lat < 20);
      check("rsp_timeout", 171'(res_lat < 20), 171'(1));
      res_st = sel ? b_rsp_status : a_rsp_status;
      res_ix = sel ? b_rsp_index : a_rsp_index;
      if (ack) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
      end
   endtask

   logic [148:0] rule1, rule2;
   int hold_bad;
   int guard2;

   initial begin
      rule1 = {21'h1ABCDE, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
      rule2 = {21'h0F0F0F, 64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444};
      rst = 1'b1; preload = 1'b1;
      a_cmd_valid = 1'b0; b_cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 1'b0; cmd_rule = '0; cmd_rule_id = '0; cmd_index = '0;
      repeat (3) @(negedge clk);

      check("rst_cmd_ready", 171'(a_cmd_ready), 171'(0));
      check("rst_rsp_valid", 171'(a_rsp_valid), 171'(0));
      check("rst_rsp_status", 171'(a_rsp_status), 171'(0));
      check("rst_rsp_index", 171'(a_rsp_index), 171'(0));
      check("rst_tbl_addr", 171'(a_tbl_addr), 171'(0));
      check("rst_tbl_we", 171'(a_tbl_we), 171'(0));
      check("rst_tbl_din", a_tbl_din, 171'(0));
      check("rst_free_cnt", 171'(a_free_cnt), 171'(0));
      check("rst_leak_cnt", 171'(a_leak_cnt), 171'(0));
      preload = 1'b0;
      rst = 1'b0;

      // Fresh insert at INIT_FILL.
      run_cmd(1'b0, 1'b0, 11'h123, 11'd0, rule1, 1'b1);
      check("ins1_lat", 171'(res_lat), 171'(3));
      check("ins1_we_cnt", 171'(res_we_cnt), 171'(1));
      check("ins1_we_addr", 171'(res_we_addr), 171'(5));
      check("ins1_we_din", res_we_din, {rule1, 11'h123, 11'd5});
      check("ins1_status", 171'(res_st), 171'(2'b00));
      check("ins1_index", 171'(res_ix), 171'(5));

      // Delete with wrong rule_id leaves the table untouched.
      run_cmd(1'b0, 1'b1, 11'h124, 11'd5, rule2, 1'b1);
      check("delmm_lat", 171'(res_lat), 171'(4));
      check("delmm_we_cnt", 171'(res_we_cnt), 171'(0));
      check("delmm_status", 171'(res_st), 171'(2'b10));

      run_cmd(1'b0, 1'b1, 11'h123, 11'd5, rule2, 1'b1);
      check("del_lat", 171'(res_lat), 171'(4));
      check("del_we_cnt", 171'(res_we_cnt), 171'(1));
      check("del_we_addr", 171'(res_we_addr), 171'(5));
      check("del_we_din", res_we_din, 171'(0));
      check("del_status", 171'(res_st), 171'(2'b00));
      check("del_index", 171'(res_ix), 171'(5));
      check("del_free_cnt", 171'(a_free_cnt), 171'(1));

      // Freed index reused; fresh allocation resumes at 6.
      run_cmd(1'b0, 1'b0, 11'h050, 11'd0, rule2, 1'b1);
      check("reuse_index", 171'(res_ix), 171'(5));
      check("reuse_free_cnt", 171'(a_free_cnt), 171'(0));
      run_cmd(1'b0, 1'b0, 11'h051, 11'd0, rule1, 1'b1);
      check("fresh_index", 171'(res_ix), 171'(6));
      check("fresh_status", 171'(res_st), 171'(2'b00));

      run_cmd(1'b0, 1'b1, 11'h000, 11'd1739, rule1, 1'b1);
      check("bad_lat", 171'(res_lat), 171'(1));
      check("bad_we_cnt", 171'(res_we_cnt), 171'(0));
      check("bad_status", 171'(res_st), 171'(2'b11));

      // 17 valid deletes into a 16-deep free list: last one leaks.
      for (int i = 0; i < 17; i++) begin
         run_cmd(1'b0, 1'b1, 11'(100 + i), 11'(100 + i), rule1, 1'b1);
         check($sformatf("bulk_del_status_%0d", i), 171'(res_st), 171'(2'b00));
      end
      check("bulk_free_cnt", 171'(a_free_cnt), 171'(16));
      check("bulk_leak_cnt", 171'(a_leak_cnt), 171'(1));

      // Backpressured response: pops 115 (last index that fit) and must hold.
      run_cmd(1'b0, 1'b0, 11'h7AA, 11'd0, rule1, 1'b0);
      check("hold_index", 171'(res_ix), 171'(115));
      check("hold_status", 171'(res_st), 171'(2'b00));
      hold_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (a_rsp_valid !== 1'b1 || a_rsp_index !== 11'd115 || a_rsp_status !== 2'b00 || a_cmd_ready !== 1'b0)
            hold_bad++;
      end
      check("hold_stable", 171'(hold_bad), 171'(0));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("hold_released", 171'(a_rsp_valid), 171'(0));
      check("hold_free_cnt", 171'(a_free_cnt), 171'(15));

      // Near-full table instance.
      run_cmd(1'b1, 1'b0, 11'h011, 11'd0, rule1, 1'b1);
      check("full1_index", 171'(res_ix), 171'(1738));
      check("full1_status", 171'(res_st), 171'(2'b00));
      run_cmd(1'b1, 1'b0, 11'h012, 11'd0, rule1, 1'b1);
      check("full2_index", 171'(res_ix), 171'(0));
      check("full2_status", 171'(res_st), 171'(2'b01));
      check("full2_we_cnt", 171'(res_we_cnt), 171'(0));

      // Reset asserted during the write cycle.
      @(negedge clk);
      cmd_op = 1'b0; cmd_rule_id = 11'h222; cmd_rule = rule2;
      a_cmd_valid = 1'b1;
      @(posedge clk);
      #1 a_cmd_valid = 1'b0;
      guard2 = 0;
      do begin
         @(negedge clk);
         guard2++;
      end while (a_tbl_we !== 1'b1 && guard2 < 10);
      check("rstw_we_before", 171'(a_tbl_we), 171'(1));
      rst = 1'b1;
      #1;
      check("rstw_we_after", 171'(a_tbl_we), 171'(0));
      check("rstw_rsp_valid", 171'(a_rsp_valid), 171'(0));
      check("rstw_free_cnt", 171'(a_free_cnt), 171'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_cmd(1'b0, 1'b0, 11'h333, 11'd0, rule1, 1'b1);
      check("rstw_hwm_index", 171'(res_ix), 171'(5));
      check("rstw_hwm_status", 171'(res_st), 171'(2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
